// File: rtl/xc_malu_pkg.sv
// Shared constants and encodings for the MALU divide engine.
package xc_malu_pkg;

  localparam int XC_MALU_XLEN = 32;
  localparam int XC_DIV_CNT_W = $clog2(XC_MALU_XLEN);

  typedef enum logic [1:0] {
    XC_DIV_IDLE = 2'd0,
    XC_DIV_RUN  = 2'd1,
    XC_DIV_DONE = 2'd2
  } xc_div_state_e;

  // Which accumulator drives the result once DONE.
  typedef enum logic [1:0] {
    XC_SEL_NONE = 2'd0,
    XC_SEL_QUO  = 2'd1,
    XC_SEL_REM  = 2'd2
  } xc_div_sel_e;

endpackage

// File: rtl/xc_malu_div_step.sv
// One restoring-division step: shift {rem,quo} left, subtract divisor if it fits.
module xc_malu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;
  logic          borrow;

  assign rem_sh = {rem_i, quo_i[XLEN-1]};
  assign trial  = rem_sh - {1'b0, divisor_i};
  // rem stays below the divisor, so a non-negative trial never sets the top bit.
  assign borrow = trial[XLEN];

  assign rem_o = borrow ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_o = {quo_i[XLEN-2:0], ~borrow};

endmodule

// File: rtl/xc_malu_divider.sv
// Iterative RV32M div/divu/rem/remu unit, 1 quotient bit per cycle, MALU valid/ready/flush responder.
module xc_malu_divider
  import xc_malu_pkg::*;
#(
  parameter int XLEN = XC_MALU_XLEN
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  input  logic            valid,
  input  logic            uop_div,
  input  logic            uop_divu,
  input  logic            uop_rem,
  input  logic            uop_remu,
  output logic [XLEN-1:0] result,
  output logic            ready
);

  localparam int CNT_W = $clog2(XLEN);

  xc_div_state_e state_q, state_d;
  xc_div_sel_e   sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic [XLEN-1:0] rem_nx, quo_nx;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            op_sgn;
  xc_div_sel_e     op_sel;

  xc_malu_div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_nx),
    .quo_o     (quo_nx)
  );

  // Uop decode with priority div > divu > rem > remu.
  always_comb begin
    op_sgn = 1'b0;
    op_sel = XC_SEL_NONE;
    if (uop_div) begin
      op_sgn = 1'b1;
      op_sel = XC_SEL_QUO;
    end else if (uop_divu) begin
      op_sel = XC_SEL_QUO;
    end else if (uop_rem) begin
      op_sgn = 1'b1;
      op_sel = XC_SEL_REM;
    end else if (uop_remu) begin
      op_sel = XC_SEL_REM;
    end
  end

  assign rs1_mag = (op_sgn && rs1[XLEN-1]) ? -rs1 : rs1;
  assign rs2_mag = (op_sgn && rs2[XLEN-1]) ? -rs2 : rs2;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      XC_DIV_IDLE: begin
        if (valid && !flush) begin
          sel_d = op_sel;
          cnt_d = '0;
          if (rs2 == '0 || op_sel == XC_SEL_NONE) begin
            // Divide-by-zero answers come straight from the raw operands.
            state_d = XC_DIV_DONE;
            quo_d   = '1;
            rem_d   = rs1;
            dvs_d   = rs2;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
          end else begin
            state_d = XC_DIV_RUN;
            quo_d   = rs1_mag;
            rem_d   = '0;
            dvs_d   = rs2_mag;
            negq_d  = op_sgn & (rs1[XLEN-1] ^ rs2[XLEN-1]);
            negr_d  = op_sgn & rs1[XLEN-1];
          end
        end
      end
      XC_DIV_RUN: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == CNT_W'(XLEN-1)) begin
          state_d = XC_DIV_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      XC_DIV_DONE: state_d = XC_DIV_DONE;
      default:     state_d = XC_DIV_IDLE;
    endcase
    if (flush) begin
      state_d = XC_DIV_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= XC_DIV_IDLE;
      sel_q   <= XC_SEL_NONE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign ready = (state_q == XC_DIV_DONE);

  always_comb begin
    result = '0;
    if (ready) begin
      case (sel_q)
        XC_SEL_QUO: result = negq_q ? -quo_q : quo_q;
        XC_SEL_REM: result = negr_q ? -rem_q : rem_q;
        default:    result = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_xc_malu_divider.sv
// Directed + randomized checks of xc_malu_divider against an RV32M arithmetic model.
module tb_xc_malu_divider;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] rs1, rs2;
  logic        flush, valid;
  logic [3:0]  uop;   // [0]=div [1]=divu [2]=rem [3]=remu
  logic [31:0] result;
  logic        ready;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] U_DIV = 4'b0001, U_DIVU = 4'b0010, U_REM = 4'b0100, U_REMU = 4'b1000;

  xc_malu_divider #(.XLEN(32)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .rs1      (rs1),
    .rs2      (rs2),
    .flush    (flush),
    .valid    (valid),
    .uop_div  (uop[0]),
    .uop_divu (uop[1]),
    .uop_rem  (uop[2]),
    .uop_remu (uop[3]),
    .result   (result),
    .ready    (ready)
  );

  always #5 clock = ~clock;

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // RV32M reference semantics, first set uop wins.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] u);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (u[0]) return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
    if (u[1]) return (b == 0) ? 32'hFFFF_FFFF : a / b;
    if (u[2]) return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
    if (u[3]) return (b == 0) ? a : a % b;
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] u);
    rs1 = a; rs2 = b; uop = u; valid = 1'b1;
  endtask

  // Called in cycle 0 (just after an edge, valid already high); counts cycles until ready.
  task automatic wait_ready(input string tag, input int exp_lat, input bit scramble);
    int cyc = 0;
    forever begin
      @(negedge clock);
      if (ready === 1'b1 || cyc > 200) break;
      if (scramble && cyc >= 1) begin
        rs1 = $urandom; rs2 = $urandom; uop = 4'($urandom); valid = 1'($urandom);
      end
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
  endtask

  // At the ready cycle: check result, flush, confirm return to IDLE.
  task automatic finish_op(input string tag, input logic [31:0] exp);
    chk({tag, "_result"}, result, exp);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; valid = 1'b0;
    chk({tag, "_ready_after_flush"}, 32'(ready), 32'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] u, input bit scramble, input bit align);
    if (align) begin
      @(posedge clock); #1;
    end
    drive(a, b, u);
    wait_ready(tag, (b == 0 || u == 0) ? 1 : 33, scramble);
    finish_op(tag, model(a, b, u));
  endtask

  initial begin
    logic [31:0] a, b;
    logic [3:0]  u;
    resetn = 1'b0; flush = 1'b0; valid = 1'b0; rs1 = '0; rs2 = '0; uop = '0;
    #12;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_result", result, 32'd0);
    @(posedge clock); #1 resetn = 1'b1;

    // Basic unsigned / signed / divide-by-zero / overflow
    run("divu_100_7", 32'd100, 32'd7, U_DIVU, 0, 1);
    run("remu_100_7", 32'd100, 32'd7, U_REMU, 0, 1);
    run("div_m7_2", 32'hFFFF_FFF9, 32'd2, U_DIV, 0, 1);
    run("rem_m7_2", 32'hFFFF_FFF9, 32'd2, U_REM, 0, 1);
    run("div_5_0", 32'd5, 32'd0, U_DIV, 0, 1);
    run("remu_5_0", 32'd5, 32'd0, U_REMU, 0, 1);
    run("divu_5_0", 32'd5, 32'd0, U_DIVU, 0, 1);
    run("rem_m5_0", 32'hFFFF_FFFB, 32'd0, U_REM, 0, 1);
    run("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, U_DIV, 0, 1);
    run("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, U_REM, 0, 1);
    run("no_uop", 32'd77, 32'd5, 4'b0000, 0, 1);
    run("prio_div_remu", 32'hFFFF_FF00, 32'd16, 4'b1001, 0, 1);
    run("prio_divu_rem", 32'hFFFF_FF00, 32'd16, 4'b0110, 0, 1);

    // Abort mid-RUN, then new op held from the flush cycle onward
    @(posedge clock); #1;
    drive(32'd1000, 32'd3, U_DIVU);
    repeat (11) @(negedge clock);
    chk("abort_ready_before_flush", 32'(ready), 32'd0);
    flush = 1'b1; rs1 = 32'd9; rs2 = 32'd3;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("abort_ready_after_flush", 32'(ready), 32'd0);
    wait_ready("after_abort", 33, 0);
    finish_op("after_abort", 32'd3);

    // Back-to-back: flush with valid held, next op sampled the following cycle
    run("b2b_first", 32'd100, 32'd7, U_DIVU, 0, 1);
    run("b2b_second", 32'hFFFF_FFFF, 32'h10, U_DIVU, 0, 0);

    // Async reset mid-RUN and while DONE
    @(posedge clock); #1;
    drive(32'd12345, 32'd7, U_DIVU);
    repeat (21) @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    chk("rst_run_ready", 32'(ready), 32'd0);
    chk("rst_run_result", result, 32'd0);
    @(posedge clock); #1 resetn = 1'b1; valid = 1'b0;
    @(posedge clock); #1;
    drive(32'd12345, 32'd7, U_DIVU);
    wait_ready("rst_done", 33, 0);
    chk("rst_done_result_pre", result, 32'd1763);
    #1 resetn = 1'b0;
    #1;
    chk("rst_done_ready", 32'(ready), 32'd0);
    chk("rst_done_result", result, 32'd0);
    @(posedge clock); #1 resetn = 1'b1; valid = 1'b0;

    // Randomized ops; odd iterations also scramble inputs while busy
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 255);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 17);
        default: b = $urandom;
      endcase
      u = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      run($sformatf("rnd%0d", i), a, b, u, 1'(i & 1), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
